port_io_ctrl: RTL and testbench
===============================

PORT_IO_CTRL -- requirements
Module: port_io_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles in PEND before the word is dropped (range 1..255).
REQ-002 Port CLK1, input, 1: sole clock; all state changes on its rising edge.
REQ-003 Port arst, input, 1: reset, synchronous, active-low (0 = reset, sampled on rising CLK1).
REQ-004 Port port_id, input, 8: processor I/O address.
REQ-005 Port write_strobe, input, 1: one-cycle processor write qualifier.
REQ-006 Port read_strobe, input, 1: one-cycle processor read qualifier.
REQ-007 Port out_port, input, 8: processor write data.
REQ-008 Port sw, input, 8: switch inputs, readable by processor.
REQ-009 Port cnt_val, input, 8: free-running counter value, readable by processor.
REQ-010 Port in_port, output, 8: registered read data to processor.
REQ-011 Port word, output, 16: committed word for the binary-to-BCD/display path.
REQ-012 Port word_valid, output, 1: word offered downstream; held until accepted or timed out.
REQ-013 Port word_ready, input, 1: downstream accepts word when high together with word_valid.
REQ-014 Port status, output, 8: {4'b0, timeout_flag, overflow_flag, pend, 1'b0}.

Function
REQ-015 Write decode (write_strobe=1): 0x01 -> stage_lo <= out_port; 0x02 -> stage_hi <= out_port; 0x03 -> commit request (data ignored); 0x05 -> clear overflow_flag and timeout_flag; any other port_id ignored.
REQ-016 FSM states IDLE and PEND only; reset state IDLE.
REQ-017 IDLE + commit request -> word <= {stage_hi, stage_lo}, word_valid <= 1, timer <= 0, go to PEND (word_valid visible the cycle after the strobe).
REQ-018 PEND: word and word_valid held stable; word_valid && word_ready on a rising edge -> word_valid <= 0, accept_cnt increments, go to IDLE.
REQ-019 PEND, no acceptance: timer increments by 1 per cycle; when timer reaches TIMEOUT-1 without acceptance -> word_valid <= 0, timeout_flag <= 1, go to IDLE; word register retains its last value.
REQ-020 Commit request while in PEND -> request discarded, overflow_flag <= 1, word unchanged, timer not restarted.
REQ-021 Acceptance and timeout on the same edge -> acceptance wins; timeout_flag not set.
REQ-022 Staging writes (0x01/0x02) are accepted in any state and never alter word while in PEND.
REQ-023 Clear (0x05) on the same edge as a flag-setting event -> set wins.
REQ-024 accept_cnt is 8 bits and wraps 255 -> 0 with no flag.
REQ-025 Read mux, registered every cycle regardless of read_strobe: in_port <= (port_id==0x00) cnt_val; 0x01 sw; 0x04 status; 0x06 accept_cnt; 0x07 word[7:0]; 0x08 word[15:8]; otherwise 0x00; one-cycle latency from port_id.
REQ-026 read_strobe has no side effects (no clear-on-read).
REQ-027 status bit1 = pend = (state==PEND), bit2 = overflow_flag, bit3 = timeout_flag.

Reset
REQ-028 arst=0 at a rising edge -> state IDLE; word, stage_lo, stage_hi, timer, accept_cnt, in_port = 0; word_valid, overflow_flag, timeout_flag = 0.
REQ-029 Reset asserted in PEND -> word_valid low the next cycle; the pending word is discarded, not delivered.
REQ-030 Reset overrides all same-cycle writes and word_ready.

Verification
REQ-031 Write 0x34 to 0x01, 0x12 to 0x02, strobe 0x03, word_ready=1 -> word=0x1234, word_valid high exactly 1 cycle, accept_cnt=1, read 0x06 returns 0x01.
REQ-032 Commit with word_ready=0, TIMEOUT=4 -> word_valid high 4 cycles then low; status=0x08; write 0x05 -> status=0x00.
REQ-033 Commit, second commit while PEND with new staging 0xBEEF -> overflow_flag=1, word still first value; after accept, read 0x04 = 0x04.
REQ-034 Commit with word_ready=0, assert arst=0 for 1 cycle mid-PEND -> word_valid=0, word=0x0000, status=0x00, accept_cnt unchanged at 0.
REQ-035 port_id=0x00 with cnt_val=0x5A, then port_id=0x01 with sw=0xC3 -> in_port=0x5A then 0xC3, each one cycle after port_id; port_id=0x09 -> 0x00.
REQ-036 256 accepted commits -> accept_cnt wraps to 0x00, no flags set.

Source files
------------

// File: rtl/port_io_ctrl.sv
// rtl/port_io_ctrl.sv - processor I/O port decoder with single-word commit/handshake path
module port_io_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK1,
    input  logic        arst,
    input  logic [7:0]  port_id,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic [7:0]  out_port,
    input  logic [7:0]  sw,
    input  logic [7:0]  cnt_val,
    output logic [7:0]  in_port,
    output logic [15:0] word,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  status
);

    // Last timer value before the pending word is dropped.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_stage_lo;
    logic [7:0]  r_stage_hi;
    logic [15:0] r_word;
    logic        r_word_valid;
    logic [7:0]  r_timer;
    logic [7:0]  r_accept_cnt;
    logic        r_overflow_flag;
    logic        r_timeout_flag;
    logic [7:0]  r_in_port;

    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_commit;
    logic        w_clear;
    logic        w_pend;
    logic        w_accept;
    logic        w_timeout;
    logic        w_load;
    logic        w_overflow_set;
    logic [7:0]  w_status;
    logic [7:0]  w_rd_data;

    // Reads are a pure mux; read_strobe only qualifies the processor side.
    logic        w_unused_rd;
    assign w_unused_rd = read_strobe;

    assign w_wr_lo  = write_strobe && (port_id == 8'h01);
    assign w_wr_hi  = write_strobe && (port_id == 8'h02);
    assign w_commit = write_strobe && (port_id == 8'h03);
    assign w_clear  = write_strobe && (port_id == 8'h05);

    assign w_pend    = (r_state == ST_PEND);
    // Acceptance is checked first so it always beats a same-edge timeout.
    assign w_accept  = w_pend && r_word_valid && word_ready;
    assign w_timeout = w_pend && !w_accept && (r_timer == TMO_LAST);

    assign w_status = {4'b0000, r_timeout_flag, r_overflow_flag, w_pend, 1'b0};

    // State register.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and commit/overflow decisions.
    always_comb begin
        w_next_state   = r_state;
        w_load         = 1'b0;
        w_overflow_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_commit) begin
                    w_load       = 1'b1;
                    w_next_state = ST_PEND;
                end
            end
            ST_PEND: begin
                if (w_accept || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
                if (w_commit) begin
                    w_overflow_set = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Staging registers are writable in any state; they only reach word on a load.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_stage_lo <= 8'h00;
            r_stage_hi <= 8'h00;
        end else begin
            if (w_wr_lo) begin
                r_stage_lo <= out_port;
            end
            if (w_wr_hi) begin
                r_stage_hi <= out_port;
            end
        end
    end

    // Word register, valid flag and pend timer.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_word       <= 16'h0000;
            r_word_valid <= 1'b0;
            r_timer      <= 8'h00;
        end else if (w_load) begin
            r_word       <= {r_stage_hi, r_stage_lo};
            r_word_valid <= 1'b1;
            r_timer      <= 8'h00;
        end else if (w_accept || w_timeout) begin
            r_word_valid <= 1'b0;
        end else if (w_pend) begin
            r_timer <= r_timer + 8'h01;
        end
    end

    // Acceptance counter, wraps silently.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_accept_cnt <= 8'h00;
        end else if (w_accept) begin
            r_accept_cnt <= r_accept_cnt + 8'h01;
        end
    end

    // Sticky flags; a same-edge set beats the clear.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_overflow_flag <= 1'b0;
            r_timeout_flag  <= 1'b0;
        end else begin
            if (w_overflow_set) begin
                r_overflow_flag <= 1'b1;
            end else if (w_clear) begin
                r_overflow_flag <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (w_clear) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    // Read data selection by port_id.
    always_comb begin
        w_rd_data = 8'h00;
        case (port_id)
            8'h00:   w_rd_data = cnt_val;
            8'h01:   w_rd_data = sw;
            8'h04:   w_rd_data = w_status;
            8'h06:   w_rd_data = r_accept_cnt;
            8'h07:   w_rd_data = r_word[7:0];
            8'h08:   w_rd_data = r_word[15:8];
            default: w_rd_data = 8'h00;
        endcase
    end

    // Read data is registered every cycle, giving one cycle of latency.
    always_ff @(posedge CLK1) begin
        if (!arst) begin
            r_in_port <= 8'h00;
        end else begin
            r_in_port <= w_rd_data;
        end
    end

    assign in_port    = r_in_port;
    assign word       = r_word;
    assign word_valid = r_word_valid;
    assign status     = w_status;

endmodule

// File: tb/tb_port_io_ctrl.sv
// tb/tb_port_io_ctrl.sv - directed-vector bench for port_io_ctrl
module tb_port_io_ctrl;

    logic        CLK1;
    logic        arst;
    logic [7:0]  port_id;
    logic        write_strobe;
    logic        read_strobe;
    logic [7:0]  out_port;
    logic [7:0]  sw;
    logic [7:0]  cnt_val;
    logic [7:0]  in_port;
    logic [15:0] word;
    logic        word_valid;
    logic        word_ready;
    logic [7:0]  status;

    int n_cmp;
    int n_bad;

    port_io_ctrl #(.TIMEOUT(4)) dut (
        .CLK1         (CLK1),
        .arst         (arst),
        .port_id      (port_id),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .out_port     (out_port),
        .sw           (sw),
        .cnt_val      (cnt_val),
        .in_port      (in_port),
        .word         (word),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .status       (status)
    );

    initial CLK1 = 1'b0;
    always #5 CLK1 = ~CLK1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK1);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
        port_id      = 8'h09;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] data);
        port_id     = addr;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        data        = in_port;
        port_id     = 8'h09;
    endtask

    task automatic do_reset();
        arst = 1'b0;
        tick();
        arst = 1'b1;
    endtask

    logic [7:0] r;
    int         n;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        arst = 1'b0; port_id = 8'h09; write_strobe = 1'b0; read_strobe = 1'b0;
        out_port = 8'h00; sw = 8'h00; cnt_val = 8'h00; word_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {15'd0, word_valid}, 16'h0000);
        chk("rst_word", word, 16'h0000);
        chk("rst_status", {8'h00, status}, 16'h0000);
        chk("rst_inport", {8'h00, in_port}, 16'h0000);
        arst = 1'b1;

        // Basic commit with immediate acceptance
        word_ready = 1'b1;
        wr(8'h01, 8'h34);
        wr(8'h02, 8'h12);
        wr(8'h03, 8'h00);
        chk("b_valid_hi", {15'd0, word_valid}, 16'h0001);
        chk("b_word", word, 16'h1234);
        tick();
        chk("b_valid_lo", {15'd0, word_valid}, 16'h0000);
        rd(8'h06, r);
        chk("b_acc_cnt", {8'h00, r}, 16'h0001);
        chk("b_status", {8'h00, status}, 16'h0000);

        // Timeout with TIMEOUT=4
        word_ready = 1'b0;
        wr(8'h03, 8'h00);
        n = 0;
        while (word_valid && n < 20) begin
            n++;
            tick();
        end
        chk("t_valid_cycles", 16'(n), 16'd4);
        chk("t_status", {8'h00, status}, 16'h0008);
        chk("t_word_kept", word, 16'h1234);
        rd(8'h04, r);
        chk("t_rd_status1", {8'h00, r}, 16'h0008);
        rd(8'h04, r);
        chk("t_rd_status2", {8'h00, r}, 16'h0008);
        wr(8'h05, 8'h00);
        chk("t_cleared", {8'h00, status}, 16'h0000);

        // Overflow; acceptance coincides with timer expiry
        wr(8'h01, 8'h11);
        wr(8'h02, 8'h22);
        wr(8'h03, 8'h00);
        wr(8'h01, 8'hEF);
        wr(8'h02, 8'hBE);
        wr(8'h03, 8'h00);
        chk("o_status", {8'h00, status}, 16'h0006);
        chk("o_word", word, 16'h2211);
        chk("o_still_valid", {15'd0, word_valid}, 16'h0001);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        chk("o_accepted", {15'd0, word_valid}, 16'h0000);
        rd(8'h04, r);
        chk("o_rd_status", {8'h00, r}, 16'h0004);
        rd(8'h06, r);
        chk("o_acc_cnt", {8'h00, r}, 16'h0002);
        rd(8'h07, r);
        chk("o_rd_word_lo", {8'h00, r}, 16'h0011);
        rd(8'h08, r);
        chk("o_rd_word_hi", {8'h00, r}, 16'h0022);
        wr(8'h05, 8'h00);

        // Reset mid-PEND overriding a same-cycle write and word_ready
        do_reset();
        word_ready = 1'b0;
        wr(8'h01, 8'h5A);
        wr(8'h02, 8'hA5);
        wr(8'h03, 8'h00);
        chk("r_pend_word", word, 16'hA55A);
        tick();
        arst = 1'b0; word_ready = 1'b1;
        port_id = 8'h01; out_port = 8'hFF; write_strobe = 1'b1;
        tick();
        arst = 1'b1; write_strobe = 1'b0; port_id = 8'h09;
        chk("r_valid", {15'd0, word_valid}, 16'h0000);
        chk("r_word", word, 16'h0000);
        chk("r_status", {8'h00, status}, 16'h0000);
        rd(8'h06, r);
        chk("r_acc_cnt", {8'h00, r}, 16'h0000);
        wr(8'h03, 8'h00);
        chk("r_stage_zero", word, 16'h0000);
        tick();

        // Read mux and latency
        cnt_val = 8'h5A;
        sw      = 8'hC3;
        port_id = 8'h00;
        tick();
        chk("m_cnt", {8'h00, in_port}, 16'h005A);
        port_id = 8'h01;
        #1;
        chk("m_latency", {8'h00, in_port}, 16'h005A);
        tick();
        chk("m_sw", {8'h00, in_port}, 16'h00C3);
        port_id = 8'h09;
        tick();
        chk("m_unmapped", {8'h00, in_port}, 16'h0000);

        // accept_cnt wrap
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            wr(8'h03, 8'h00);
            tick();
        end
        rd(8'h06, r);
        chk("w_cnt_255", {8'h00, r}, 16'h00FF);
        wr(8'h03, 8'h00);
        tick();
        rd(8'h06, r);
        chk("w_cnt_wrap", {8'h00, r}, 16'h0000);
        chk("w_status", {8'h00, status}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
